// File: rtl/sram_bus_responder_if.sv
// Controller-side strobe/address and responder status flags of the SRAM bus.
// The bidirectional data bus stays a plain inout port on the responder.
interface sram_bus_responder_if #(
    parameter int unsigned ADDR_W = 18
) ();
    logic              SRAM_WE_N;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              rd_valid;
    logic              wr_done;
    logic              addr_err;

    modport master (
        output SRAM_WE_N,
        output SRAM_ADDR,
        input  rd_valid,
        input  wr_done,
        input  addr_err
    );

    modport slave (
        input  SRAM_WE_N,
        input  SRAM_ADDR,
        output rd_valid,
        output wr_done,
        output addr_err
    );
endinterface

// File: rtl/sram_bus_responder.sv
// Single-port SRAM responder with read latency and minimum write-strobe width.
// Define SRAM_RESP_STATS_EN to add the rd_count/wr_count access counters.
module sram_bus_responder #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 65536,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_bus_responder_if.slave bus,
    inout  wire  [DATA_W-1:0]   SRAM_DQ
`ifdef SRAM_RESP_STATS_EN
    ,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
`endif
);
    localparam int unsigned   IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [3:0]    RD_LAST = 4'(READ_LAT);
    localparam logic [3:0]    WR_LAST = 4'(WR_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdDrive,
        StWrWait,
        StWrDone
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_d;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wr_done;
    logic               r_addr_err;
    logic               w_wr_done_d;
    logic               w_addr_err_d;
    logic               w_commit;
    logic               w_addr_same;
    logic               w_in_range;
    logic               w_drive;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_rd_data;
    logic [DATA_W-1:0]  r_mem [MEM_DEPTH];

    assign w_addr_same = (bus.SRAM_ADDR == r_addr);
    assign w_in_range  = ({1'b0, r_addr} < DEPTH_L);
    assign w_idx       = r_addr[IDX_W-1:0];

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_commit     = 1'b0;
        w_wr_done_d  = 1'b0;
        w_addr_err_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d   = 4'd1;
                w_state_d = bus.SRAM_WE_N ? StRdWait : StWrWait;
            end
            StRdWait: begin
                if (!bus.SRAM_WE_N) begin
                    w_state_d = StWrWait;
                    w_cnt_d   = 4'd1;
                end else if (!w_addr_same) begin
                    w_cnt_d = 4'd1;
                end else if (r_cnt >= RD_LAST) begin
                    w_state_d    = StRdDrive;
                    w_addr_err_d = !w_in_range;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StRdDrive: begin
                if (!bus.SRAM_WE_N) begin
                    w_state_d = StWrWait;
                    w_cnt_d   = 4'd1;
                end else if (!w_addr_same) begin
                    w_state_d = StRdWait;
                    w_cnt_d   = 4'd1;
                end
            end
            StWrWait: begin
                if (bus.SRAM_WE_N) begin
                    w_state_d = StRdWait;
                    w_cnt_d   = 4'd1;
                end else if (!w_addr_same) begin
                    w_cnt_d = 4'd1;
                end else if ((r_cnt + 4'd1) >= WR_LAST) begin
                    // Out-of-range writes still park in WR_DONE so a held strobe is ignored.
                    w_state_d    = StWrDone;
                    w_commit     = w_in_range;
                    w_wr_done_d  = w_in_range;
                    w_addr_err_d = !w_in_range;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StWrDone: begin
                if (bus.SRAM_WE_N) begin
                    w_state_d = StRdWait;
                    w_cnt_d   = 4'd1;
                end else if (!w_addr_same) begin
                    w_state_d = StWrWait;
                    w_cnt_d   = 4'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Every transition either keeps the address or relatches it, so always capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wr_done  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_addr     <= bus.SRAM_ADDR;
            r_wr_done  <= w_wr_done_d;
            r_addr_err <= w_addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_commit) begin
            r_mem[w_idx] <= SRAM_DQ;
        end
    end

    // Drop the bus combinationally as soon as the controller moves away.
    assign w_drive   = (r_state == StRdDrive) && bus.SRAM_WE_N && w_addr_same;
    assign w_rd_data = w_in_range ? r_mem[w_idx] : {DATA_W{1'b1}};
    assign SRAM_DQ   = w_drive ? w_rd_data : {DATA_W{1'bz}};

    assign bus.rd_valid = w_drive;
    assign bus.wr_done  = r_wr_done;
    assign bus.addr_err = r_addr_err;

`ifdef SRAM_RESP_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            if ((r_state == StRdWait) && (w_state_d == StRdDrive)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_commit) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: directed vector table, bus-release corner cases,
// then random traffic checked against a run-length protocol model.
module tb_sram_bus_responder;
    localparam int RL    = 2;
    localparam int WC    = 2;
    localparam int DEPTH = 65536;

    logic        clk;
    logic        rst;
    logic        tb_drv;
    logic [15:0] tb_wd;
    wire  [15:0] dq;

    int n_checks;
    int n_fail;

    sram_bus_responder_if #(.ADDR_W(18)) bus_if ();

`ifdef SRAM_RESP_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    sram_bus_responder #(
        .ADDR_W   (18),
        .DATA_W   (16),
        .MEM_DEPTH(DEPTH),
        .READ_LAT (RL),
        .WR_CYCLES(WC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .SRAM_DQ (dq)
`ifdef SRAM_RESP_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    assign dq = tb_drv ? tb_wd : 16'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: length of the current run of identical (we, addr) samples.
    int          run;
    logic        pwe;
    logic [17:0] paddr;
    logic        exp_rv;
    logic        exp_wd;
    logic        exp_ae;
    logic        exp_inr;
    logic [15:0] mem_m [int];
    logic [15:0] m_rd_cnt;
    logic [15:0] m_wr_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic we, input logic [17:0] a,
                              input logic [15:0] wd);
        if (!r) begin
            run      = 0;
            exp_rv   = 1'b0;
            exp_wd   = 1'b0;
            exp_ae   = 1'b0;
            m_rd_cnt = 16'd0;
            m_wr_cnt = 16'd0;
        end else begin
            if (run > 0 && we == pwe && a == paddr) begin
                if (run < 1000) run++;
            end else begin
                run = 1;
            end
            exp_inr = (int'(a) < DEPTH);
            exp_rv  = we && (run >= RL + 1);
            exp_wd  = !we && (run == WC) && exp_inr;
            exp_ae  = !exp_inr && ((we && run == RL + 1) || (!we && run == WC));
            if (we && run == RL + 1) m_rd_cnt = m_rd_cnt + 16'd1;
            if (exp_wd) begin
                mem_m[int'(a)] = wd;
                m_wr_cnt       = m_wr_cnt + 16'd1;
            end
        end
        pwe   = we;
        paddr = a;
    endtask

    task automatic step(input logic r, input logic we, input logic [17:0] a,
                        input logic [15:0] wd);
        @(negedge clk);
        rst                = r;
        bus_if.SRAM_WE_N   = we;
        bus_if.SRAM_ADDR   = a;
        tb_wd              = wd;
        tb_drv             = !we;
        @(posedge clk);
        model_edge(r, we, a, wd);
        #1;
    endtask

    task automatic check_model(input int idx);
        check($sformatf("rnd%0d rd_valid", idx), 32'(bus_if.rd_valid), 32'(exp_rv));
        check($sformatf("rnd%0d wr_done", idx), 32'(bus_if.wr_done), 32'(exp_wd));
        check($sformatf("rnd%0d addr_err", idx), 32'(bus_if.addr_err), 32'(exp_ae));
        if (exp_rv) begin
            if (!exp_inr) begin
                check($sformatf("rnd%0d dq_oor", idx), 32'(dq), 32'hFFFF);
            end else if (mem_m.exists(int'(paddr))) begin
                check($sformatf("rnd%0d dq", idx), 32'(dq), 32'(mem_m[int'(paddr)]));
            end
        end
    endtask

    typedef struct {
        logic        r;
        logic        we;
        logic [17:0] a;
        logic [15:0] wd;
        logic        rv;
        logic        wdn;
        logic        ae;
        logic        chk;
        logic [15:0] dq;
    } vec_t;

    function automatic vec_t v(input logic r, input logic we, input logic [17:0] a,
                               input logic [15:0] wd, input logic rv, input logic wdn,
                               input logic ae, input logic chk, input logic [15:0] d);
        vec_t t;
        t.r   = r;   t.we  = we;  t.a  = a;   t.wd = wd;
        t.rv  = rv;  t.wdn = wdn; t.ae = ae;  t.chk = chk; t.dq = d;
        return t;
    endfunction

    vec_t        tbl[$];
    logic [17:0] pool[7];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        run      = 0;
        pwe      = 1'b1;
        paddr    = '0;
        m_rd_cnt = 16'd0;
        m_wr_cnt = 16'd0;
        rst      = 1'b0;
        tb_drv   = 1'b0;
        tb_wd    = 16'h0;
        bus_if.SRAM_WE_N = 1'b1;
        bus_if.SRAM_ADDR = '0;

        //                r  we addr       wdata     rv wd ae chk dq
        tbl.push_back(v(0, 1, 18'h00000, 16'h0000, 0, 0, 0, 0, 16'h0000)); // reset
        tbl.push_back(v(1, 0, 18'h00010, 16'hBEEF, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 0, 18'h00010, 16'hBEEF, 0, 1, 0, 0, 16'h0000)); // commit
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 1, 0, 0, 1, 16'hBEEF)); // 3rd edge
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 1, 0, 0, 1, 16'hBEEF));
        tbl.push_back(v(1, 0, 18'h00020, 16'h5555, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 0, 18'h00020, 16'h5555, 0, 1, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00020, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 0, 18'h00020, 16'h1234, 0, 0, 0, 0, 16'h0000)); // short strobe
        tbl.push_back(v(1, 1, 18'h00020, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00020, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00020, 16'h0000, 1, 0, 0, 1, 16'h5555));
        tbl.push_back(v(1, 1, 18'h10000, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h10000, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h10000, 16'h0000, 1, 0, 1, 1, 16'hFFFF)); // oor read
        tbl.push_back(v(1, 1, 18'h10000, 16'h0000, 1, 0, 0, 1, 16'hFFFF));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 1, 0, 0, 1, 16'hBEEF));
        tbl.push_back(v(0, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000)); // reset mid-read
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 1, 0, 0, 1, 16'hBEEF));
        tbl.push_back(v(1, 0, 18'h1FFFF, 16'hAAAA, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 0, 18'h1FFFF, 16'hAAAA, 0, 0, 1, 0, 16'h0000)); // oor write
        tbl.push_back(v(1, 0, 18'h1FFFF, 16'hAAAA, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 0, 18'h00010, 16'h0BAD, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 18'h00010, 16'h0BAD, 0, 0, 0, 0, 16'h0000)); // reset in write
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(v(1, 1, 18'h00010, 16'h0000, 1, 0, 0, 1, 16'hBEEF));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].wd);
            check($sformatf("vec%0d rd_valid", i), 32'(bus_if.rd_valid), 32'(tbl[i].rv));
            check($sformatf("vec%0d wr_done", i), 32'(bus_if.wr_done), 32'(tbl[i].wdn));
            check($sformatf("vec%0d addr_err", i), 32'(bus_if.addr_err), 32'(tbl[i].ae));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d dq", i), 32'(dq), 32'(tbl[i].dq));
            end
        end

        // Bus release is combinational: check mid-cycle, before the next edge.
        @(negedge clk);
        bus_if.SRAM_ADDR = 18'h00011;
        #1 check("release_on_addr rd_valid", 32'(bus_if.rd_valid), 32'd0);
        bus_if.SRAM_ADDR = 18'h00010;
        #1 check("restore_addr rd_valid", 32'(bus_if.rd_valid), 32'd1);
        bus_if.SRAM_WE_N = 1'b0;
        #1 check("release_on_we rd_valid", 32'(bus_if.rd_valid), 32'd0);
        bus_if.SRAM_WE_N = 1'b1;
        @(posedge clk);
        model_edge(1'b1, 1'b1, 18'h00010, 16'h0000);
        #1 check("hold_after_glitch rd_valid", 32'(bus_if.rd_valid), 32'd1);
        check("hold_after_glitch dq", 32'(dq), 32'hBEEF);

        pool[0] = 18'h00010; pool[1] = 18'h00020; pool[2] = 18'h00030;
        pool[3] = 18'h00031; pool[4] = 18'h0FFFF; pool[5] = 18'h10000;
        pool[6] = 18'h3FFFF;
        for (int i = 0; i < 400; i++) begin
            logic        r_we;
            logic        r_rst;
            logic [17:0] r_a;
            int          hold;
            r_we  = 1'($urandom_range(0, 1));
            r_a   = pool[$urandom_range(0, 6)];
            hold  = int'($urandom_range(1, 5));
            r_rst = ($urandom_range(0, 40) != 0);
            for (int k = 0; k < hold; k++) begin
                step((k == 0) ? r_rst : 1'b1, r_we, r_a, 16'($urandom));
                check_model(i);
            end
        end

`ifdef SRAM_RESP_STATS_EN
        check("stats rd_count vs model", 32'(rd_count), 32'(m_rd_cnt));
        check("stats wr_count vs model", 32'(wr_count), 32'(m_wr_cnt));
        step(1'b0, 1'b1, 18'h0, 16'h0);
        for (int w = 0; w < 3; w++) begin
            step(1'b1, 1'b0, 18'h00040 + 18'(w), 16'h1000 + 16'(w));
            step(1'b1, 1'b0, 18'h00040 + 18'(w), 16'h1000 + 16'(w));
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 18'h00040 + 18'(r), 16'h0);
        end
        check("stats wr_count", 32'(wr_count), 32'd3);
        check("stats rd_count", 32'(rd_count), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bus_responder.md
SRAM_BUS_RESPONDER -- requirements
Module: sram_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 65536, number of implemented words; must not exceed 2^ADDR_W.
REQ-004 SHALL have parameter READ_LAT, default 2, range 1-15: stable-address cycles before read data is driven.
REQ-005 SHALL have parameter WR_CYCLES, default 2, range 1-15: consecutive SRAM_WE_N-low cycles needed to commit a write.
REQ-006 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-007 Port: rst  input  1  reset, synchronous, active-low.
REQ-008 Port: SRAM_WE_N  input  1  write strobe from the controller, active-low.
REQ-009 Port: SRAM_ADDR  input  ADDR_W  word address from the controller.
REQ-010 Port: SRAM_DQ  inout  DATA_W  bidirectional data bus; this block drives it only in RD_DRIVE.
REQ-011 Port: rd_valid  output  1  high while SRAM_DQ carries valid read data.
REQ-012 Port: wr_done  output  1  one-cycle pulse on the cycle a write commits.
REQ-013 Port: addr_err  output  1  one-cycle pulse when an access targets an address >= MEM_DEPTH.

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_DONE, with a 4-bit latency counter cnt.
REQ-015 IDLE: SRAM_WE_N=0 -> WR_WAIT, cnt=1, latch SRAM_ADDR; SRAM_WE_N=1 -> RD_WAIT, cnt=1, latch SRAM_ADDR.
REQ-016 RD_WAIT: SRAM_WE_N=0 -> WR_WAIT, cnt=1; address differs from latched -> relatch, cnt=1; else cnt+1, and on cnt reaching READ_LAT -> RD_DRIVE.
REQ-017 RD_DRIVE: drive SRAM_DQ = mem[latched addr], rd_valid=1; on address change or SRAM_WE_N=0, release the bus the same cycle and go to RD_WAIT or WR_WAIT with cnt=1.
REQ-018 Total read latency from a new stable address to driven data SHALL be exactly READ_LAT+1 clock edges.
REQ-019 WR_WAIT: SRAM_WE_N=1 before cnt reaches WR_CYCLES -> abort with no write, go to RD_WAIT, cnt=1; address change -> relatch, cnt=1; cnt reaching WR_CYCLES -> mem[addr]=SRAM_DQ sampled that edge, wr_done pulse, go to WR_DONE.
REQ-020 WR_DONE: stay while SRAM_WE_N=0 and the address is unchanged; a continued low strobe SHALL NOT write again; SRAM_WE_N=1 -> RD_WAIT, cnt=1; address change while low -> WR_WAIT, cnt=1.
REQ-021 SRAM_DQ SHALL be high-Z in every state except RD_DRIVE; a read and a write driver never overlap.
REQ-022 Address >= MEM_DEPTH: a read drives all-ones; a write is discarded with no wr_done; addr_err pulses once on entry into RD_DRIVE or at the would-be commit.
REQ-023 Simultaneous address change and SRAM_WE_N edge: the SRAM_WE_N level selects the next state, the new address is latched, and cnt=1.
REQ-024 Storage SHALL be MEM_DEPTH x DATA_W with a single port; read data reflects a commit made on the previous edge.

Reset
REQ-025 rst=0 at a clock edge: state=IDLE, cnt=0, SRAM_DQ high-Z, rd_valid=0, wr_done=0, addr_err=0.
REQ-026 Reset during WR_WAIT SHALL cancel the write with no memory change.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro SRAM_RESP_STATS_EN compiled in: adds outputs rd_count[15:0] and wr_count[15:0], which count RD_DRIVE entries and committed writes, wrap 0xFFFF->0, and reset to 0.
REQ-029 SRAM_RESP_STATS_EN absent: those ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-030 Write 0xBEEF to address 0x00010 with SRAM_WE_N low for 2 cycles -> wr_done pulses at the 2nd edge and mem[0x10]=0xBEEF.
REQ-031 Then SRAM_WE_N=1 with address 0x00010 held -> SRAM_DQ=0xBEEF and rd_valid=1 exactly 3 edges later; bus high-Z before that.
REQ-032 SRAM_WE_N low for 1 cycle only (WR_CYCLES=2) with data 0x1234 to address 0x20 -> no wr_done, and mem[0x20] is unchanged.
REQ-033 Read of address 0x10000 (MEM_DEPTH=65536) -> SRAM_DQ=0xFFFF and a single addr_err pulse.
REQ-034 rst=0 asserted mid-RD_DRIVE at address 0x10 -> bus high-Z next edge; after release, a re-read of 0x10 still returns 0xBEEF.
REQ-035 With SRAM_RESP_STATS_EN: 3 writes and 2 reads -> wr_count=3 and rd_count=2.
